wb_stage_mux: RTL and testbench
===============================

// Module: wb_stage_mux
// PURPOSE
//  Parametrised writeback stage for rysyCore. Selects the register-file write data from imm,
//  delayed PC, ALU result or load data, and extends load data by byte/half/word and sign.
//  Registers the result with valid/stall/flush control and drives rd_d/rd_we into reg_file.
//  PC_DELAY matches the core's PC pipeline depth.
// PARAMETERS
//  XLEN      32  data width; equals `REG_LEN
//  RADDR_W   5   destination register address width
//  PC_DELAY  1   PC delay-line depth in cycles (>=1); stage k holds pc from k advances ago
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  stall        in   1        1 = hold all state (delay line and output register)
//  flush        in   1        1 = kill the instruction being captured this edge
//  in_valid     in   1        inputs carry a real instruction
//  rd_sel       in   2        `RD_IMM / `RD_PCP4 / `RD_ALU / `RD_MEM
//  rd_addr_in   in   RADDR_W  destination register
//  imm          in   XLEN     immediate from decode
//  pc           in   XLEN     PC value to be delayed (return address source)
//  alu_out      in   XLEN     ALU result
//  rd_mem       in   XLEN     raw 32-bit word from data memory
//  ld_type      in   3        `LD_B/`LD_H/`LD_W/`LD_BU/`LD_HU
//  ld_off       in   2        byte offset of load address (addr[1:0])
//  out_valid    out  1        registered result valid
//  rd_addr_out  out  RADDR_W  registered destination register
//  rd_d         out  XLEN     registered write data
//  rd_we        out  1        out_valid && rd_addr_out != 0
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, rd_addr_out=0, rd_d=0, rd_we=0, all delay-line stages=0.
//  Delay line: on each edge with !stall, stage0<=pc, stage k<=stage k-1; the last stage is old_pc.
//   PC_DELAY=1 gives exactly one cycle of delay. The line shifts regardless of in_valid/flush.
//  Select (combinational): IMM->imm; PCP4->old_pc; ALU->alu_out; MEM->ld_ext(rd_mem).
//  ld_ext: B/BU pick rd_mem[8*ld_off +: 8]. H/HU pick the halfword at ld_off[1]; ld_off[0] is ignored
//   (no misalign trap). W ignores ld_off. B/H sign-extend; BU/HU zero-extend.
//   Reserved ld_type codes are treated as W.
//  Output register, priority at each edge: flush > stall > normal.
//   flush=1: out_valid<=0; rd_d and rd_addr_out hold. flush also overrides stall for out_valid;
//    the delay line still obeys stall.
//   stall=1 (no flush): all outputs hold.
//   normal: out_valid<=in_valid; rd_addr_out<=rd_addr_in; rd_d<=selected value.
//  Latency: 1 cycle, input to rd_d. Throughput: 1 per cycle when !stall.
//  rd_we is combinational from registered state; x0 writes never assert rd_we.
//  Reset mid-stall or mid-flush: reset wins immediately. The first edge after release is a normal capture.
// STRUCTURE
//  rysy_pkg.vh: `REG_LEN, `RD_IMM=0, `RD_PCP4=1, `RD_ALU=2, `RD_MEM=3,
//   `LD_B=0, `LD_H=1, `LD_W=2, `LD_BU=4, `LD_HU=5.
//  Sub-module load_ext (combinational: rd_mem, ld_type, ld_off -> XLEN). The delay line is a
//   generate loop in the top.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> all outputs 0; release, in_valid=0 -> out_valid stays 0.
//  2 ALU path: rd_sel=ALU, alu_out=0x1234_5678, rd_addr_in=5, in_valid=1
//    -> next cycle rd_d=0x1234_5678, rd_we=1. Repeat with rd_addr_in=0 -> rd_we=0.
//  3 PC delay: PC_DELAY=1 and 3, pc ramps 0x100,0x104,... with rd_sel=PCP4
//    -> rd_d equals pc from PC_DELAY edges before capture.
//  4 Loads: rd_mem=0x80FF_7F01. B off=3 -> 0xFFFF_FF80; BU off=1 -> 0x0000_007F;
//    H off=2 -> 0xFFFF_80FF; HU off=0 -> 0x0000_7F01; W -> 0x80FF_7F01.
//  5 Stall: stall=1 for 3 cycles while inputs change -> outputs and delay line frozen;
//    after release the captured value is the current input.
//  6 Flush vs stall: flush=1 with stall=1 and in_valid=1 -> out_valid=0 next cycle, rd_d held;
//    async reset asserted mid-stall -> outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage_mux_pkg.sv
// Shared encodings for the rysyCore writeback stage.
//   rd_sel codes pick the register-file write source.
//   ld_type codes pick the load width and signedness.
// Codes 3, 6 and 7 of ld_type are reserved. The load extender treats them as full words.
package wb_stage_mux_pkg;

    // Write-data source select
    localparam logic [1:0] RD_IMM  = 2'd0;
    localparam logic [1:0] RD_PCP4 = 2'd1;
    localparam logic [1:0] RD_ALU  = 2'd2;
    localparam logic [1:0] RD_MEM  = 2'd3;

    // Load type
    localparam logic [2:0] LD_B  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_W  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;

endpackage

// File: rtl/wb_stage_mux_load_ext.sv
// load_ext: combinational load-data extractor and extender.
// Ports:
//   rd_mem  in  XLEN  raw word from data memory (low 32 bits carry the word)
//   ld_type in  3     LD_B / LD_H / LD_W / LD_BU / LD_HU (others behave as LD_W)
//   ld_off  in  2     byte offset of the load address
//   ld_data out XLEN  extracted and extended load value
// XLEN must be at least 32.
module load_ext
    import wb_stage_mux_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rd_mem,
    input  logic [2:0]      ld_type,
    input  logic [1:0]      ld_off,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_mem[7:0];
        case (ld_off)
            2'd0:    byte_sel = rd_mem[7:0];
            2'd1:    byte_sel = rd_mem[15:8];
            2'd2:    byte_sel = rd_mem[23:16];
            default: byte_sel = rd_mem[31:24];
        endcase
    end

    // Halfword loads ignore ld_off[0]. A misaligned halfword reads the aligned half and does not trap.
    always_comb begin
        half_sel = ld_off[1] ? rd_mem[31:16] : rd_mem[15:0];
    end

    always_comb begin
        ld_data = rd_mem;
        case (ld_type)
            LD_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
            LD_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_data = rd_mem;
        endcase
    end

endmodule

// File: rtl/wb_stage_mux.sv
// wb_stage_mux: writeback stage for rysyCore.
// The stage selects the register-file write data from one of four sources:
//   - the immediate
//   - the delayed PC
//   - the ALU result
//   - the extended load data
// It then registers that data with valid/stall/flush control.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   stall                  hold delay line and output register
//   flush                  kill the instruction captured this edge (out_valid <= 0)
//   in_valid               inputs carry a real instruction
//   rd_sel                 write-data source (RD_IMM/RD_PCP4/RD_ALU/RD_MEM)
//   rd_addr_in             destination register
//   imm, pc, alu_out       data sources; pc goes through a PC_DELAY-deep delay line
//   rd_mem, ld_type, ld_off  raw load word and its extraction controls
//   out_valid, rd_addr_out, rd_d  registered result
//   rd_we                  out_valid and destination is not x0
module wb_stage_mux
    import wb_stage_mux_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int PC_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [1:0]         rd_sel,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic [XLEN-1:0]    imm,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    alu_out,
    input  logic [XLEN-1:0]    rd_mem,
    input  logic [2:0]         ld_type,
    input  logic [1:0]         ld_off,
    output logic               out_valid,
    output logic [RADDR_W-1:0] rd_addr_out,
    output logic [XLEN-1:0]    rd_d,
    output logic               rd_we
);

    // PC delay line.
    // pc_chain[0] is the live pc, and pc_chain[k] is the output of stage k-1.
    // The line shifts whenever stall is low, independent of in_valid and flush.
    logic [XLEN-1:0] pc_chain [PC_DELAY+1];
    logic [XLEN-1:0] old_pc;

    assign pc_chain[0] = pc;

    for (genvar g = 0; g < PC_DELAY; g++) begin : g_pc_stage
        logic [XLEN-1:0] stage_d;
        logic [XLEN-1:0] stage_q;

        always_comb begin
            stage_d = stall ? stage_q : pc_chain[g];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign pc_chain[g+1] = stage_q;
    end

    assign old_pc = pc_chain[PC_DELAY];

    // Write-data select
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] sel_data;

    load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .rd_mem  (rd_mem),
        .ld_type (ld_type),
        .ld_off  (ld_off),
        .ld_data (ld_data)
    );

    always_comb begin
        sel_data = alu_out;
        case (rd_sel)
            RD_IMM:  sel_data = imm;
            RD_PCP4: sel_data = old_pc;
            RD_ALU:  sel_data = alu_out;
            RD_MEM:  sel_data = ld_data;
            default: sel_data = alu_out;
        endcase
    end

    // Output register.
    // The priority order is flush, then stall, then normal capture.
    // Flush clears only the valid bit. Data and address keep their old values.
    logic               out_valid_d, out_valid_q;
    logic [RADDR_W-1:0] rd_addr_d, rd_addr_q;
    logic [XLEN-1:0]    rd_data_d, rd_data_q;

    always_comb begin
        out_valid_d = out_valid_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (!stall) begin
            out_valid_d = in_valid;
            rd_addr_d   = rd_addr_in;
            rd_data_d   = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign rd_addr_out = rd_addr_q;
    assign rd_d        = rd_data_q;
    // Writes to x0 are never forwarded to the register file
    assign rd_we       = out_valid_q && (rd_addr_q != '0);

endmodule

// File: tb/tb_wb_stage_mux.sv
// Directed bench for wb_stage_mux. It uses two instances that share every input:
//   u_d1 has PC_DELAY = 1
//   u_d3 has PC_DELAY = 3
// Inputs change 1 ns after a rising edge, and outputs are checked at the same point.
module tb_wb_stage_mux;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [1:0]  rd_sel;
    logic [4:0]  rd_addr_in;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] rd_mem;
    logic [2:0]  ld_type;
    logic [1:0]  ld_off;

    logic        ov1, we1, ov3, we3;
    logic [4:0]  ra1, ra3;
    logic [31:0] d1, d3;

    int n_vec = 0;
    int n_err = 0;

    wb_stage_mux #(.XLEN(32), .RADDR_W(5), .PC_DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rd_sel(rd_sel), .rd_addr_in(rd_addr_in), .imm(imm), .pc(pc), .alu_out(alu_out),
        .rd_mem(rd_mem), .ld_type(ld_type), .ld_off(ld_off),
        .out_valid(ov1), .rd_addr_out(ra1), .rd_d(d1), .rd_we(we1)
    );

    wb_stage_mux #(.XLEN(32), .RADDR_W(5), .PC_DELAY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rd_sel(rd_sel), .rd_addr_in(rd_addr_in), .imm(imm), .pc(pc), .alu_out(alu_out),
        .rd_mem(rd_mem), .ld_type(ld_type), .ld_off(ld_off),
        .out_valid(ov3), .rd_addr_out(ra3), .rd_d(d3), .rd_we(we3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        stall      = 1'($urandom_range(0, 1));
        flush      = 1'($urandom_range(0, 1));
        in_valid   = 1'($urandom_range(0, 1));
        rd_sel     = 2'($urandom_range(0, 3));
        rd_addr_in = 5'($urandom_range(0, 31));
        imm        = $urandom;
        pc         = $urandom;
        alu_out    = $urandom;
        rd_mem     = $urandom;
        ld_type    = 3'($urandom_range(0, 7));
        ld_off     = 2'($urandom_range(0, 3));
    endtask

    // Load vectors on rd_mem = 0x80FF_7F01
    logic [2:0]  ld_t_tab [8];
    logic [1:0]  ld_o_tab [8];
    logic [31:0] ld_e_tab [8];

    initial begin
        ld_t_tab[0] = 3'd0; ld_o_tab[0] = 2'd3; ld_e_tab[0] = 32'hFFFF_FF80; // B
        ld_t_tab[1] = 3'd4; ld_o_tab[1] = 2'd1; ld_e_tab[1] = 32'h0000_007F; // BU
        ld_t_tab[2] = 3'd1; ld_o_tab[2] = 2'd2; ld_e_tab[2] = 32'hFFFF_80FF; // H
        ld_t_tab[3] = 3'd5; ld_o_tab[3] = 2'd0; ld_e_tab[3] = 32'h0000_7F01; // HU
        ld_t_tab[4] = 3'd2; ld_o_tab[4] = 2'd3; ld_e_tab[4] = 32'h80FF_7F01; // W ignores off
        ld_t_tab[5] = 3'd1; ld_o_tab[5] = 2'd3; ld_e_tab[5] = 32'hFFFF_80FF; // H, off[0] ignored
        ld_t_tab[6] = 3'd0; ld_o_tab[6] = 2'd0; ld_e_tab[6] = 32'h0000_0001; // B positive
        ld_t_tab[7] = 3'd7; ld_o_tab[7] = 2'd1; ld_e_tab[7] = 32'h80FF_7F01; // reserved -> W
    end

    // Timeout guard
    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with random inputs
        rst_n = 1'b0;
        randomize_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            randomize_inputs();
        end
        #1;
        check("rst_ov1", {31'd0, ov1}, 32'd0);
        check("rst_ra1", {27'd0, ra1}, 32'd0);
        check("rst_d1",  d1,           32'd0);
        check("rst_we1", {31'd0, we1}, 32'd0);
        check("rst_ov3", {31'd0, ov3}, 32'd0);
        check("rst_d3",  d3,           32'd0);

        rst_n    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        rd_sel   = 2'd2;
        step();
        check("idle_ov1", {31'd0, ov1}, 32'd0);
        check("idle_we1", {31'd0, we1}, 32'd0);

        // 2: ALU path
        rd_sel     = 2'd2;
        alu_out    = 32'h1234_5678;
        rd_addr_in = 5'd5;
        in_valid   = 1'b1;
        step();
        check("alu_d1",  d1,           32'h1234_5678);
        check("alu_ra1", {27'd0, ra1}, 32'd5);
        check("alu_ov1", {31'd0, ov1}, 32'd1);
        check("alu_we1", {31'd0, we1}, 32'd1);
        check("alu_d3",  d3,           32'h1234_5678);
        rd_addr_in = 5'd0;
        alu_out    = 32'h0BAD_F00D;
        step();
        check("x0_d1",  d1,           32'h0BAD_F00D);
        check("x0_ov1", {31'd0, ov1}, 32'd1);
        check("x0_we1", {31'd0, we1}, 32'd0);
        check("x0_we3", {31'd0, we3}, 32'd0);

        // 3: PC delay ramp
        rd_sel     = 2'd1;
        rd_addr_in = 5'd1;
        for (int i = 0; i < 8; i++) begin
            pc = 32'h100 + 32'(4 * i);
            step();
            if (i >= 1) check("pc_d1", d1, 32'h100 + 32'(4 * (i - 1)));
            if (i >= 3) check("pc_d3", d3, 32'h100 + 32'(4 * (i - 3)));
        end

        // 4: loads
        rd_sel = 2'd3;
        rd_mem = 32'h80FF_7F01;
        for (int i = 0; i < 8; i++) begin
            ld_type = ld_t_tab[i];
            ld_off  = ld_o_tab[i];
            step();
            check("load_d1", d1, ld_e_tab[i]);
        end

        // 5: stall freezes outputs and the delay line
        rd_sel     = 2'd0;
        imm        = 32'hAAAA_0001;
        rd_addr_in = 5'd7;
        in_valid   = 1'b1;
        pc         = 32'h200;
        step();
        check("pre_stall_d1", d1, 32'hAAAA_0001);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imm        = 32'h1111_0000 + 32'(i);
            rd_addr_in = 5'(10 + i);
            in_valid   = 1'b0;
            pc         = 32'h300 + 32'(4 * i);
            rd_sel     = 2'(i);
            step();
            check("stall_d1",  d1,           32'hAAAA_0001);
            check("stall_ra1", {27'd0, ra1}, 32'd7);
            check("stall_ov1", {31'd0, ov1}, 32'd1);
        end
        stall    = 1'b0;
        rd_sel   = 2'd1;
        pc       = 32'h400;
        in_valid = 1'b1;
        rd_addr_in = 5'd9;
        step();
        check("unstall_pc_d1", d1,           32'h200);
        check("unstall_ra1",   {27'd0, ra1}, 32'd9);
        rd_sel  = 2'd0;
        imm     = 32'h0000_0055;
        step();
        check("unstall_imm_d1", d1, 32'h0000_0055);

        // 6: flush versus stall
        rd_sel     = 2'd2;
        alu_out    = 32'hCAFE_0000;
        rd_addr_in = 5'd3;
        in_valid   = 1'b1;
        step();
        check("pre_flush_ov1", {31'd0, ov1}, 32'd1);
        flush   = 1'b1;
        stall   = 1'b1;
        alu_out = 32'hDEAD_0000;
        rd_addr_in = 5'd4;
        step();
        check("flush_stall_ov1", {31'd0, ov1}, 32'd0);
        check("flush_stall_d1",  d1,           32'hCAFE_0000);
        check("flush_stall_ra1", {27'd0, ra1}, 32'd3);
        check("flush_stall_we1", {31'd0, we1}, 32'd0);
        stall   = 1'b0;
        alu_out = 32'hBEEF_0000;
        step();
        check("flush_ov1", {31'd0, ov1}, 32'd0);
        check("flush_d1",  d1,           32'hCAFE_0000);

        // async reset in the middle of a stall
        flush   = 1'b0;
        alu_out = 32'h7777_0001;
        rd_addr_in = 5'd6;
        step();
        check("pre_rst_we1", {31'd0, we1}, 32'd1);
        stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ov1", {31'd0, ov1}, 32'd0);
        check("async_d1",  d1,           32'd0);
        check("async_ra1", {27'd0, ra1}, 32'd0);
        check("async_we1", {31'd0, we1}, 32'd0);
        step();
        rst_n   = 1'b1;
        stall   = 1'b0;
        alu_out = 32'h0000_ABCD;
        rd_addr_in = 5'd2;
        step();
        check("post_rst_d1",  d1,           32'h0000_ABCD);
        check("post_rst_we1", {31'd0, we1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
